// File: rtl/seg7_display_scanner_if.sv
// rtl/seg7_display_scanner_if.sv - display data/drive bundle for the seg7 scanner
interface seg7_display_scanner_if;
  logic [3:0] res;
  logic [7:0] btn_counter;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output res, btn_counter,
    input  anode, seg, dp, frame_done
  );

  modport slave (
    input  res, btn_counter,
    output anode, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_display_scanner.sv
// rtl/seg7_display_scanner.sv - 4-digit multiplexed 7-seg scanner: res, dash, btn_counter
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks digit 3 when the counter's high nibble is 0.
module seg7_display_scanner #(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input logic                    clock,
  input logic                    reset,
  seg7_display_scanner_if.slave  disp
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc;
  logic             tick;
  logic             wrap;
  scan_state_t      state, state_nxt;
  logic [3:0]       res_s;
  logic [7:0]       cnt_s;
  logic             load_pending;
  logic [3:0]       anode_nxt, anode_q;
  logic [6:0]       seg_nxt, seg_q;
  logic             fd_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (presc == DIV_LAST);
  assign wrap = tick && (state == DIG3);

  always_ff @(posedge clock) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + DIV_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= DIG0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    anode_nxt = 4'b1111;
    seg_nxt   = 7'b1111111;
    case (state)
      DIG0: begin
        if (tick) state_nxt = DIG1;
        anode_nxt = 4'b1110;
        seg_nxt   = hex7(res_s);
      end
      DIG1: begin
        if (tick) state_nxt = DIG2;
        anode_nxt = 4'b1101;
        seg_nxt   = 7'b0111111;
      end
      DIG2: begin
        if (tick) state_nxt = DIG3;
        anode_nxt = 4'b1011;
        seg_nxt   = hex7(cnt_s[3:0]);
      end
      DIG3: begin
        if (tick) state_nxt = DIG0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Slot still takes its full time; only the drive is suppressed.
        if (cnt_s[7:4] != 4'h0) begin
          anode_nxt = 4'b0111;
          seg_nxt   = hex7(cnt_s[7:4]);
        end
`else
        anode_nxt = 4'b0111;
        seg_nxt   = hex7(cnt_s[7:4]);
`endif
      end
    endcase
  end

  // Snapshot only at frame boundaries so a frame never mixes old and new data.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_s        <= 4'h0;
      cnt_s        <= 8'h00;
      load_pending <= 1'b1;
    end else begin
      if (load_pending || wrap) begin
        res_s <= disp.res;
        cnt_s <= disp.btn_counter;
      end
      load_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
      fd_q    <= 1'b0;
    end else begin
      anode_q <= anode_nxt;
      seg_q   <= seg_nxt;
      fd_q    <= wrap;
    end
  end

  assign disp.anode      = anode_q;
  assign disp.seg        = seg_q;
  assign disp.dp         = 1'b1;
  assign disp.frame_done = fd_q;

endmodule
